// File: rtl/fod_phe_lane_collect_if.sv
// ---------------------------------------------------------------------------
// fod_phe_lane_collect_if
//   Bundle of the frame input, averaging control and result signals of the
//   multi-lane phase-detect sample collector.
//
//   master : drives en / psamp / avg_en / avg_k / err_clr, observes results
//   slave  : the collector itself
//
//   en       frame valid this cycle
//   psamp    NLANE*SEG retimed phase snapshots, lane l at [l*SEG +: SEG]
//   avg_en   averaging engine enable
//   avg_k    averaging window exponent (window = 2**avg_k frames)
//   err_clr  synchronous clear of err_cnt
//   phe_x    decoded phase per lane, lane l at [l*SEG_BIN +: SEG_BIN]
//   phe_vld  phe_x / phe_err updated this cycle
//   phe_err  per-lane bubble flag of the current frame
//   avg_x    averaged phase per lane, left-aligned, SEG_BIN+AVG_MAX bits each
//   avg_vld  one-cycle pulse, avg_x updated
//   err_cnt  saturating count of frames with at least one lane error
// ---------------------------------------------------------------------------
interface fod_phe_lane_collect_if #(
  parameter int NLANE   = 4,
  parameter int SEG_BIN = 3,
  parameter int AVG_MAX = 6,
  parameter int ERRW    = 8
);
  localparam int SEG = 1 << SEG_BIN;
  localparam int AW  = SEG_BIN + AVG_MAX;

  logic                      en;
  logic [NLANE*SEG-1:0]      psamp;
  logic                      avg_en;
  logic [2:0]                avg_k;
  logic                      err_clr;
  logic [NLANE*SEG_BIN-1:0]  phe_x;
  logic                      phe_vld;
  logic [NLANE-1:0]          phe_err;
  logic [NLANE*AW-1:0]       avg_x;
  logic                      avg_vld;
  logic [ERRW-1:0]           err_cnt;

  modport master (
    output en, psamp, avg_en, avg_k, err_clr,
    input  phe_x, phe_vld, phe_err, avg_x, avg_vld, err_cnt
  );

  modport slave (
    input  en, psamp, avg_en, avg_k, err_clr,
    output phe_x, phe_vld, phe_err, avg_x, avg_vld, err_cnt
  );
endinterface

// File: rtl/fod_phe_lane_collect.sv
// ---------------------------------------------------------------------------
// fod_phe_lane_collect
//   N-lane phase-detect sample collector for the multi-lane FOD controller.
//   Each lane carries a circular thermometer snapshot of the multiphase
//   divider (already retimed to dig_clk). The word is decoded to the index of
//   its single rising edge; words with zero or several edges are bubbles and
//   reuse the lane's last good phase. A two-stage pipeline (input register,
//   decode register) produces the PHE bus one frame per cycle. An optional
//   engine averages 2**K frames per lane with phase unwrapping relative to
//   the first frame of the window and reports the result left-aligned with
//   AVG_MAX-K extra fractional bits.
//
//   dig_clk  clock, one frame per cycle when en=1
//   arst     asynchronous active-high reset
//   bus      fod_phe_lane_collect_if.slave (see interface header)
// ---------------------------------------------------------------------------
module fod_phe_lane_collect #(
  parameter int NLANE   = 4,
  parameter int SEG_BIN = 3,
  parameter int AVG_MAX = 6,
  parameter int ERRW    = 8
) (
  input  logic                         dig_clk,
  input  logic                         arst,
  fod_phe_lane_collect_if.slave        bus
);
  localparam int SEG = 1 << SEG_BIN;
  localparam int AW  = SEG_BIN + AVG_MAX;
  localparam int CW  = AVG_MAX + 1;

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  // stage 1: raw frame
  logic                     s1_vld_reg;
  logic [NLANE*SEG-1:0]     s1_word_reg;

  // stage 2: decoded frame; phe_x_reg doubles as each lane's last good phase
  logic [SEG_BIN-1:0]       phe_x_reg [NLANE];
  logic [NLANE-1:0]         phe_err_reg;
  logic                     phe_vld_reg;
  logic [ERRW-1:0]          err_cnt_reg;

  // decode of the stage-1 word
  logic [SEG_BIN-1:0]       dec_phase [NLANE];
  logic [NLANE-1:0]         dec_err;

  // averaging engine
  state_t                   state_reg, state_next;
  logic [2:0]               kc_reg, kc_next;
  logic [CW-1:0]            cnt_reg, cnt_next;
  logic [SEG_BIN-1:0]       ref_reg [NLANE];
  logic [SEG_BIN-1:0]       ref_next [NLANE];
  logic signed [AW-1:0]     acc_reg [NLANE];
  logic signed [AW-1:0]     acc_next [NLANE];
  logic [AW-1:0]            avg_x_reg [NLANE];
  logic [AW-1:0]            avg_x_next [NLANE];
  logic                     avg_vld_reg, avg_vld_next;
  logic [2:0]               kc_clamp;
  logic                     complete;
  logic [SEG_BIN-1:0]       diff_v;
  logic [AW-1:0]            sum_v;

  // packed views of the per-lane outputs
  logic [NLANE*SEG_BIN-1:0] phe_x_pk;
  logic [NLANE*AW-1:0]      avg_x_pk;

  // -------------------------------------------------------------------------
  // Stage 1
  // -------------------------------------------------------------------------
  always_ff @(posedge dig_clk or posedge arst) begin
    if (arst) begin
      s1_vld_reg  <= 1'b0;
      s1_word_reg <= '0;
    end else begin
      s1_vld_reg  <= bus.en;
      s1_word_reg <= bus.psamp;
    end
  end

  // -------------------------------------------------------------------------
  // Per-lane circular thermometer decode
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
    logic [SEG-1:0]     word;
    logic [SEG-1:0]     edge_vec;
    logic [SEG_BIN-1:0] edge_idx;
    logic               one_edge;

    assign word = s1_word_reg[gi*SEG +: SEG];

    // bit i is a rising edge when it is set and its circular predecessor is clear
    for (genvar gj = 0; gj < SEG; gj++) begin : g_edge
      assign edge_vec[gj] = word[gj] & ~word[(gj + SEG - 1) % SEG];
    end

    // exactly one edge: non-zero and a power of two
    assign one_edge = (edge_vec != '0) && ((edge_vec & (edge_vec - SEG'(1))) == '0);

    always_comb begin
      edge_idx = '0;
      for (int i = 0; i < SEG; i++) begin
        if (edge_vec[i]) edge_idx = i[SEG_BIN-1:0];
      end
    end

    assign dec_err[gi]   = ~one_edge;
    assign dec_phase[gi] = one_edge ? edge_idx : phe_x_reg[gi];
  end

  // -------------------------------------------------------------------------
  // Stage 2 and error counter
  // -------------------------------------------------------------------------
  always_ff @(posedge dig_clk or posedge arst) begin
    if (arst) begin
      phe_vld_reg <= 1'b0;
      phe_err_reg <= '0;
      err_cnt_reg <= '0;
      for (int l = 0; l < NLANE; l++) phe_x_reg[l] <= '0;
    end else begin
      phe_vld_reg <= s1_vld_reg;
      if (s1_vld_reg) begin
        phe_err_reg <= dec_err;
        for (int l = 0; l < NLANE; l++) phe_x_reg[l] <= dec_phase[l];
      end
      // clear wins over a coincident increment
      if (bus.err_clr) begin
        err_cnt_reg <= '0;
      end else if (s1_vld_reg && (|dec_err) && (err_cnt_reg != '1)) begin
        err_cnt_reg <= err_cnt_reg + ERRW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Averaging FSM. It consumes frames as they enter stage 2 so that the
  // completing frame's AVG_VLD lines up with that same frame's PHE_VLD.
  // -------------------------------------------------------------------------
  always_ff @(posedge dig_clk or posedge arst) begin
    if (arst) begin
      state_reg   <= ST_IDLE;
      kc_reg      <= '0;
      cnt_reg     <= '0;
      avg_vld_reg <= 1'b0;
      for (int l = 0; l < NLANE; l++) begin
        ref_reg[l]   <= '0;
        acc_reg[l]   <= '0;
        avg_x_reg[l] <= '0;
      end
    end else begin
      state_reg   <= state_next;
      kc_reg      <= kc_next;
      cnt_reg     <= cnt_next;
      avg_vld_reg <= avg_vld_next;
      for (int l = 0; l < NLANE; l++) begin
        ref_reg[l]   <= ref_next[l];
        acc_reg[l]   <= acc_next[l];
        avg_x_reg[l] <= avg_x_next[l];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    kc_next      = kc_reg;
    cnt_next     = cnt_reg;
    ref_next     = ref_reg;
    acc_next     = acc_reg;
    avg_x_next   = avg_x_reg;
    avg_vld_next = 1'b0;
    complete     = 1'b0;
    diff_v       = '0;
    sum_v        = '0;
    kc_clamp     = (int'(bus.avg_k) > AVG_MAX) ? 3'(AVG_MAX) : bus.avg_k;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.avg_en && s1_vld_reg) begin
          kc_next  = kc_clamp;
          cnt_next = CW'(1);
          for (int l = 0; l < NLANE; l++) begin
            ref_next[l] = dec_phase[l];
            acc_next[l] = '0;
          end
          if (kc_clamp == 3'd0) complete   = 1'b1;
          else                  state_next = ST_ACC;
        end
      end
      ST_ACC: begin
        if (!bus.avg_en) begin
          // abandon the window; avg_x keeps the last completed result
          state_next = ST_IDLE;
        end else if (s1_vld_reg) begin
          for (int l = 0; l < NLANE; l++) begin
            // modular difference read as signed gives the shortest unwrap step
            diff_v      = dec_phase[l] - ref_reg[l];
            acc_next[l] = acc_reg[l] + {{AVG_MAX{diff_v[SEG_BIN-1]}}, diff_v};
          end
          cnt_next = cnt_reg + CW'(1);
          if (cnt_next == (CW'(1) << kc_reg)) begin
            complete   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (complete) begin
      avg_vld_next = 1'b1;
      for (int l = 0; l < NLANE; l++) begin
        sum_v = (AW'(ref_next[l]) << kc_next) + AW'(acc_next[l]);
        // left shift drops bits above SEG_BIN+Kc, which is the circular wrap
        avg_x_next[l] = sum_v << (AVG_MAX - int'(kc_next));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    phe_x_pk = '0;
    avg_x_pk = '0;
    for (int l = 0; l < NLANE; l++) begin
      phe_x_pk[l*SEG_BIN +: SEG_BIN] = phe_x_reg[l];
      avg_x_pk[l*AW +: AW]           = avg_x_reg[l];
    end
  end

  assign bus.phe_x   = phe_x_pk;
  assign bus.phe_vld = phe_vld_reg;
  assign bus.phe_err = phe_err_reg;
  assign bus.avg_x   = avg_x_pk;
  assign bus.avg_vld = avg_vld_reg;
  assign bus.err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_fod_phe_lane_collect.sv
// ---------------------------------------------------------------------------
// tb_fod_phe_lane_collect
//   Directed bench for fod_phe_lane_collect (NLANE=4, SEG=8, AVG_MAX=6,
//   ERRW=4). Inputs change 1 ns after the rising edge and outputs are
//   checked there as well.
// ---------------------------------------------------------------------------
module tb_fod_phe_lane_collect;
  logic dig_clk;
  logic arst;
  int   vectors;
  int   miscompares;
  int   fidx;
  logic last_d;

  fod_phe_lane_collect_if #(.NLANE(4), .SEG_BIN(3), .AVG_MAX(6), .ERRW(4)) bus_if ();

  fod_phe_lane_collect #(.NLANE(4), .SEG_BIN(3), .AVG_MAX(6), .ERRW(4)) dut (
    .dig_clk (dig_clk),
    .arst    (arst),
    .bus     (bus_if)
  );

  initial dig_clk = 1'b0;
  always #5 dig_clk = ~dig_clk;

  task automatic tick();
    @(posedge dig_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // 4-bit thermometer whose rising edge sits at bit p
  function automatic logic [7:0] th(input logic [2:0] p);
    logic [15:0] t;
    t = 16'h0F0F << p;
    return t[15:8];
  endfunction

  function automatic logic [31:0] fr(input logic [2:0] p0, p1, p2, p3);
    return {th(p3), th(p2), th(p1), th(p0)};
  endfunction

  function automatic logic [11:0] px(input logic [2:0] p0, p1, p2, p3);
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [35:0] ax(input logic [8:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  logic [2:0] t4_l0 [4] = '{3'd7, 3'd0, 3'd0, 3'd7};
  logic [2:0] t5_l0 [4] = '{3'd2, 3'd1, 3'd0, 3'd7};
  logic [2:0] t5_l1 [4] = '{3'd0, 3'd4, 3'd4, 3'd4};
  logic [2:0] t6_l0 [4] = '{3'd5, 3'd5, 3'd6, 3'd6};
  logic       t6_en [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    vectors        = 0;
    miscompares    = 0;
    fidx           = 0;
    last_d         = 1'b0;
    arst           = 1'b1;
    bus_if.en      = 1'b0;
    bus_if.psamp   = '0;
    bus_if.avg_en  = 1'b0;
    bus_if.avg_k   = 3'd0;
    bus_if.err_clr = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_phe_x",   bus_if.phe_x,   0);
    chk("rst_phe_vld", bus_if.phe_vld, 0);
    chk("rst_phe_err", bus_if.phe_err, 0);
    chk("rst_avg_x",   bus_if.avg_x,   0);
    chk("rst_avg_vld", bus_if.avg_vld, 0);
    chk("rst_err_cnt", bus_if.err_cnt, 0);
    arst = 1'b0;
    tick();

    // clean frame, two-cycle latency
    bus_if.en    = 1'b1;
    bus_if.psamp = 32'hF03C1E0F;
    tick();
    bus_if.en = 1'b0;
    chk("t1_lat_vld", bus_if.phe_vld, 0);
    tick();
    chk("t1_vld",   bus_if.phe_vld, 1);
    chk("t1_phe_x", bus_if.phe_x,   12'h888);
    chk("t1_err",   bus_if.phe_err, 0);
    chk("t1_cnt",   bus_if.err_cnt, 0);
    tick();
    chk("t1_vld_drop", bus_if.phe_vld, 0);
    chk("t1_hold",     bus_if.phe_x,   12'h888);

    // bubble frames on lane 2 keep its last good phase
    bus_if.en    = 1'b1;
    bus_if.psamp = 32'hF05A1E0F;
    tick();
    bus_if.psamp = 32'hF0001E0F;
    tick();
    bus_if.en = 1'b0;
    chk("t2a_phe_x", bus_if.phe_x,   12'h888);
    chk("t2a_err",   bus_if.phe_err, 4'b0100);
    chk("t2a_cnt",   bus_if.err_cnt, 1);
    tick();
    chk("t2b_phe_x", bus_if.phe_x,   12'h888);
    chk("t2b_err",   bus_if.phe_err, 4'b0100);
    chk("t2b_cnt",   bus_if.err_cnt, 2);

    // saturation of the 4-bit counter
    bus_if.en    = 1'b1;
    bus_if.psamp = 32'hF0001E0F;
    repeat (20) tick();
    bus_if.en = 1'b0;
    tick();
    chk("t3_sat", bus_if.err_cnt, 15);

    // clear beats a coincident increment
    bus_if.en = 1'b1;
    tick();
    bus_if.en      = 1'b0;
    bus_if.err_clr = 1'b1;
    tick();
    bus_if.err_clr = 1'b0;
    chk("t3_clr_vld", bus_if.phe_vld, 1);
    chk("t3_clr",     bus_if.err_cnt, 0);

    // all lanes bubbled counts once per frame
    bus_if.en    = 1'b1;
    bus_if.psamp = '0;
    tick();
    bus_if.en = 1'b0;
    tick();
    chk("t3_all_err", bus_if.phe_err, 4'hF);
    chk("t3_all_x",   bus_if.phe_x,   12'h888);
    chk("t3_one_inc", bus_if.err_cnt, 1);

    // 4-frame average with wrap on lane 0: phases 7,0,0,7 -> 480
    bus_if.avg_en = 1'b1;
    bus_if.avg_k  = 3'd2;
    for (int k = 0; k < 6; k++) begin
      bus_if.en = (k < 4);
      if (k < 4) bus_if.psamp = fr(t4_l0[k], 3'd1, 3'd2, 3'd4);
      tick();
      chk($sformatf("t4_phe_vld_%0d", k), bus_if.phe_vld, (k >= 1 && k <= 4));
      chk($sformatf("t4_avg_vld_%0d", k), bus_if.avg_vld, (k == 4));
      if (k == 4) chk("t4_avg_x", bus_if.avg_x, ax(9'd480, 9'd64, 9'd128, 9'd256));
    end
    chk("t4_avg_hold", bus_if.avg_x, ax(9'd480, 9'd64, 9'd128, 9'd256));

    // abort after two frames, then a fresh window with negative steps
    bus_if.en    = 1'b1;
    bus_if.psamp = fr(3'd3, 3'd3, 3'd2, 3'd4);
    tick();
    tick();
    bus_if.en = 1'b0;
    chk("t5_g0_avg_vld", bus_if.avg_vld, 0);
    tick();
    chk("t5_g1_avg_vld", bus_if.avg_vld, 0);
    bus_if.avg_en = 1'b0;
    tick();
    chk("t5_abort_vld",  bus_if.avg_vld, 0);
    chk("t5_abort_hold", bus_if.avg_x, ax(9'd480, 9'd64, 9'd128, 9'd256));
    bus_if.avg_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus_if.en = (k < 4);
      if (k < 4) bus_if.psamp = fr(t5_l0[k], t5_l1[k], 3'd2, 3'd4);
      tick();
      chk($sformatf("t5_avg_vld_%0d", k), bus_if.avg_vld, (k == 4));
      if (k == 4) chk("t5_avg_x", bus_if.avg_x, ax(9'd32, 9'd320, 9'd128, 9'd256));
    end

    // EN gaps inside a window are not counted
    for (int i = 0; i < 9; i++) begin
      bus_if.en = t6_en[i];
      if (t6_en[i]) bus_if.psamp = fr(t6_l0[fidx], 3'd3, 3'd2, 3'd4);
      tick();
      chk($sformatf("t6_avg_vld_%0d", i), bus_if.avg_vld, last_d);
      if (last_d) chk("t6_avg_x", bus_if.avg_x, ax(9'd352, 9'd192, 9'd128, 9'd256));
      last_d = t6_en[i] && (fidx == 3);
      if (t6_en[i]) fidx++;
    end

    // async reset in the middle of a window
    bus_if.en    = 1'b1;
    bus_if.psamp = fr(3'd1, 3'd1, 3'd1, 3'd1);
    tick();
    tick();
    bus_if.en = 1'b0;
    tick();
    chk("t6_pre_rst_x", bus_if.phe_x, px(3'd1, 3'd1, 3'd1, 3'd1));
    #2;
    arst = 1'b1;
    #1;
    chk("t6_rst_phe_x",   bus_if.phe_x,   0);
    chk("t6_rst_phe_vld", bus_if.phe_vld, 0);
    chk("t6_rst_phe_err", bus_if.phe_err, 0);
    chk("t6_rst_avg_x",   bus_if.avg_x,   0);
    chk("t6_rst_avg_vld", bus_if.avg_vld, 0);
    chk("t6_rst_err_cnt", bus_if.err_cnt, 0);
    tick();
    arst = 1'b0;
    bus_if.avg_en = 1'b0;
    tick();
    chk("t6_post_rst_x", bus_if.phe_x, 0);

    // bubbles right after reset fall back to phase 0
    bus_if.en    = 1'b1;
    bus_if.psamp = '0;
    tick();
    bus_if.en = 1'b0;
    tick();
    chk("t6_held0_x",   bus_if.phe_x,   0);
    chk("t6_held0_err", bus_if.phe_err, 4'hF);
    chk("t6_held0_cnt", bus_if.err_cnt, 1);

    // AVG_K=7 clamps to 6: 64-frame window, FSM starts clean after reset
    bus_if.avg_en = 1'b1;
    bus_if.avg_k  = 3'd7;
    bus_if.psamp  = fr(3'd1, 3'd2, 3'd3, 3'd5);
    for (int i = 0; i < 66; i++) begin
      bus_if.en = (i < 64);
      tick();
      chk($sformatf("t7_avg_vld_%0d", i), bus_if.avg_vld, (i == 64));
    end
    chk("t7_avg_x", bus_if.avg_x, ax(9'd64, 9'd128, 9'd192, 9'd320));

    // AVG_K=0 completes on the very first frame
    bus_if.avg_k = 3'd0;
    bus_if.en    = 1'b1;
    bus_if.psamp = fr(3'd7, 3'd0, 3'd0, 3'd0);
    tick();
    bus_if.en = 1'b0;
    chk("t8_avg_vld_early", bus_if.avg_vld, 0);
    tick();
    chk("t8_avg_vld", bus_if.avg_vld, 1);
    chk("t8_avg_x",   bus_if.avg_x, ax(9'd448, 9'd0, 9'd0, 9'd0));
    tick();
    chk("t8_avg_vld_drop", bus_if.avg_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
